// File: rtl/uart_rx_fifo_if.sv
// Bus between the UART receive front end and the core.
// Handshake: rdreq pops the head entry at a clock edge only when empty is
// low at that edge (rdreq while empty is ignored); q is the head entry and
// reads 8'h00 while empty; frame_err/overrun are one-cycle pulses.
interface uart_rx_fifo_if;
  logic       rx;
  logic       rdreq;
  logic [7:0] q;
  logic       empty;
  logic       full;
  logic       frame_err;
  logic       overrun;
  logic [2:0] dbg_state;

  modport master (
    output rx, rdreq,
    input  q, empty, full, frame_err, overrun, dbg_state
  );

  modport slave (
    input  rx, rdreq,
    output q, empty, full, frame_err, overrun, dbg_state
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 serial receiver feeding a show-ahead FIFO. A stop bit sampled low
// raises frame_err and parks the receiver until the line returns high;
// a good byte arriving while the FIFO is full (and not being popped) is
// dropped with an overrun pulse.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DEPTH        = 16
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_fifo_if.slave  bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(DEPTH);

  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  logic          r_sync1, r_sync2;
  logic          w_rxs;
  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_idx, w_idx_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          w_push, w_ferr;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_empty, w_full, w_pop, w_wr, w_ovr;
  logic          r_frame_err, r_overrun;

  // Two-flop synchronizer; resets to the idle-high line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= bus.rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rxs = r_sync2;

  // Receiver state, bit-period counter, bit index and shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  // Receiver next-state: mid-bit sampling, push on a good stop bit.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_ONE;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_push      = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (!w_rxs) w_state_nxt = S_START;
      end
      S_START: begin
        if (r_cnt == HALF_LAST) begin
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          // A line that is high again mid start bit was only a glitch.
          w_state_nxt = w_rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {w_rxs, r_shift[7:1]};
          w_idx_nxt   = r_idx + 3'd1;
          if (r_idx == 3'd7) w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_nxt = '0;
          if (w_rxs) begin
            w_push      = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_ferr      = 1'b1;
            w_state_nxt = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // Hold here so a line stuck low does not yield repeated 0x00 bytes.
        w_cnt_nxt = '0;
        if (w_rxs) w_state_nxt = S_IDLE;
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == DEPTH_CNT);
  assign w_pop   = bus.rdreq && !w_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_wr    = w_push && (!w_full || w_pop);
  assign w_ovr   = w_push && w_full && !w_pop;

  // FIFO storage write; contents are don't-care until count covers them.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= w_shift_nxt;
  end

  // FIFO pointers, occupancy and registered debug pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_frame_err <= w_ferr;
      r_overrun   <= w_ovr;
    end
  end

  assign bus.q         = w_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign bus.empty     = w_empty;
  assign bus.full      = w_full;
  assign bus.frame_err = r_frame_err;
  assign bus.overrun   = r_overrun;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo with an 8-clock bit period and a 4-entry FIFO.
module tb_uart_rx_fifo;

  localparam int CPB   = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_rx_fifo_if bus();

  uart_rx_fifo #(
    .CLKS_PER_BIT(CPB),
    .DEPTH       (DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int n_ferr = 0;
  int n_ovr = 0;
  int n_fall = 0;
  int exp_ferr = 0;
  int exp_ovr = 0;
  logic prev_empty = 1'b1;

  // Pulse and empty-edge monitors, sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.frame_err) n_ferr = n_ferr + 1;
    if (bus.overrun) n_ovr = n_ovr + 1;
    if (prev_empty && !bus.empty) n_fall = n_fall + 1;
    prev_empty = bus.empty;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one 8N1 frame. Optionally pops on the stop-bit sample edge, or
  // resets the DUT partway through data bit 4.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                            input logic pop_at_push, input logic abort_mid);
    logic [7:0] e;
    @(posedge clk);
    #1;
    bus.rx = 1'b0;
    repeat (CPB) begin
      @(posedge clk);
      #1;
    end
    for (int b = 0; b < 8; b++) begin
      bus.rx = d[b];
      for (int c = 1; c <= CPB; c++) begin
        @(posedge clk);
        #1;
        if (abort_mid && b == 4 && c == 3) begin
          rst = 1'b1;
          @(posedge clk);
          #1;
          rst = 1'b0;
          bus.rx = 1'b1;
          exp_q.delete();
          return;
        end
      end
    end
    bus.rx = stop_bit;
    for (int c = 1; c <= CPB; c++) begin
      @(posedge clk);
      #1;
      if (c == CPB - 1) bus.rdreq = 1'b0;
      if (pop_at_push && c == CPB - 2) begin
        bus.rdreq = 1'b1;
        @(negedge clk);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        check("q_at_push", {24'd0, bus.q}, {24'd0, e});
      end
    end
    if (stop_bit) bus.rx = 1'b1;
  endtask

  // Good frame: the model decides whether the FIFO accepts it or overruns.
  task automatic send_good(input logic [7:0] d, input logic pop_at_push);
    send_frame(d, 1'b1, pop_at_push, 1'b0);
    if (exp_q.size() < DEPTH) exp_q.push_back(d);
    else exp_ovr = exp_ovr + 1;
    idle(2);
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    @(negedge clk);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
    check(tag, {24'd0, bus.q}, {24'd0, e});
    bus.rdreq = 1'b1;
    @(posedge clk);
    #1;
    bus.rdreq = 1'b0;
  endtask

  task automatic check_drained(input string tag);
    @(negedge clk);
    check({tag, "_empty"}, {31'd0, bus.empty}, 32'd1);
    check({tag, "_q0"}, {24'd0, bus.q}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int falls0;
    logic [7:0] r;
    bus.rx = 1'b1;
    bus.rdreq = 1'b0;
    idle(3);
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_empty", {31'd0, bus.empty}, 32'd1);
    check("rst_full", {31'd0, bus.full}, 32'd0);
    check("rst_q", {24'd0, bus.q}, 32'd0);
    check("rst_ferr", {31'd0, bus.frame_err}, 32'd0);
    check("rst_ovr", {31'd0, bus.overrun}, 32'd0);
    check("rst_state", {29'd0, bus.dbg_state}, 32'd0);

    // 1. Single byte
    falls0 = n_fall;
    send_good(8'hA5, 1'b0);
    check("t1_falls", n_fall - falls0, 32'd1);
    pop_check("t1_q");
    check_drained("t1");

    // 2. Glitch rejection
    @(posedge clk);
    #1;
    bus.rx = 1'b0;
    idle(2);
    bus.rx = 1'b1;
    idle(30);
    @(negedge clk);
    check("t2_empty", {31'd0, bus.empty}, 32'd1);
    check("t2_state", {29'd0, bus.dbg_state}, 32'd0);
    send_good(8'h3C, 1'b0);
    pop_check("t2_q");

    // 3. Framing error, line held low, then recovery
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    exp_ferr = exp_ferr + 1;
    idle(40);
    bus.rx = 1'b1;
    idle(6);
    check("t3_ferr", n_ferr, exp_ferr);
    check("t3_empty", {31'd0, bus.empty}, 32'd1);
    send_good(8'h01, 1'b0);
    pop_check("t3_q");
    check_drained("t3");

    // 4. Overrun
    for (int i = 0; i < 4; i++) send_good(8'h10 + 8'(i), 1'b0);
    @(negedge clk);
    check("t4_full", {31'd0, bus.full}, 32'd1);
    send_good(8'h14, 1'b0);
    check("t4_ovr", n_ovr, exp_ovr);
    check("t4_full2", {31'd0, bus.full}, 32'd1);
    for (int i = 0; i < 4; i++) pop_check("t4_q");
    check_drained("t4");

    // 5. Push and pop together while full
    for (int i = 0; i < 4; i++) send_good(8'h20 + 8'(i), 1'b0);
    send_good(8'h24, 1'b1);
    check("t5_ovr", n_ovr, exp_ovr);
    @(negedge clk);
    check("t5_full", {31'd0, bus.full}, 32'd1);
    for (int i = 0; i < 4; i++) pop_check("t5_q");
    check_drained("t5");

    // 6. Reset mid-frame
    send_good(8'h11, 1'b0);
    send_good(8'h22, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b1);
    idle(100);
    check_drained("t6");
    check("t6_state", {29'd0, bus.dbg_state}, 32'd0);
    send_good(8'h7E, 1'b0);
    pop_check("t6_q");

    // Random bytes, two queued then drained
    for (int k = 0; k < 3; k++) begin
      r = 8'($urandom_range(0, 255));
      send_good(r, 1'b0);
      r = 8'($urandom_range(0, 255));
      send_good(r, 1'b0);
      pop_check("rnd_q");
      pop_check("rnd_q");
    end
    check_drained("rnd");
    check("end_ferr", n_ferr, exp_ferr);
    check("end_ovr", n_ovr, exp_ovr);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Serial receive front end for the core's UART port. Deserializes an 8N1 line into bytes and buffers them in a show-ahead FIFO. The FIFO's `q`/`empty`/`rdreq` connect directly to the core's `uart_in`/`uart_empty`/`uart_rdreq`. Framing errors and overruns are reported as single-cycle pulses for debug LEDs.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per bit period (50 MHz / 115200). Must be ≥ 4.
- `DEPTH`, default 16: FIFO entries. Must be a power of two and ≥ 2.
- `clk` in 1: the single clock. All logic is on posedge.
- `rst` in 1: reset, synchronous and active-high.
- `rx` in 1: asynchronous serial line, idle high.
- `rdreq` in 1: pop the head entry at this clock edge. Ignored while `empty`.
- `q` out 8: head byte. Reads 8'h00 whenever `empty`.
- `empty` out 1: FIFO holds 0 entries.
- `full` out 1: FIFO holds `DEPTH` entries.
- `frame_err` out 1: one-cycle pulse when a stop bit is sampled low.
- `overrun` out 1: one-cycle pulse when a good byte is dropped because the FIFO is full.

## Operation
- Synchronizer: `rx` passes through two flops, both reset to 1. All receiver logic uses the synchronized `rxs`.
- The receiver FSM has four states: IDLE, START, DATA, STOP, plus BREAK. A bit-period counter of width clog2(`CLKS_PER_BIT`) and a bit index of 3 bits support it.
  - IDLE: when `rxs`==0, go to START and clear the counter.
  - START: when the counter reaches `CLKS_PER_BIT`/2−1, sample `rxs`. If it is 0, go to DATA with counter and index cleared. If it is 1 (glitch), return to IDLE with no output.
  - DATA: every `CLKS_PER_BIT` cycles, shift `rxs` into the shift register, LSB first. After bit index 7, go to STOP.
  - STOP: after `CLKS_PER_BIT` cycles, sample `rxs`.
    - If it is 1, assert push of the shift register, then go to IDLE.
    - If it is 0, pulse `frame_err`, discard the byte, and go to BREAK.
  - BREAK: wait for `rxs`==1, then go to IDLE. This prevents a held-low line from producing repeated 0x00 bytes.
- FIFO storage: `DEPTH`×8 register array with write pointer, read pointer (both clog2(`DEPTH`) bits, natural wrap) and a count of clog2(`DEPTH`)+1 bits.
  - `empty` = (count==0).
  - `full` = (count==`DEPTH`).
  - `q` = empty ? 0 : mem[rdptr].
- Push occurs when push is asserted and (!full or a pop happens in the same cycle). Push when full with no pop: drop the byte, pulse `overrun`, leave the FIFO unchanged.
- Pop occurs when `rdreq` and !empty.
- Simultaneous push and pop: both happen, count is unchanged, and the pointers both advance. When full, this writes the slot being freed and accepts the byte (no overrun).
- Push when empty with `rdreq` high: `rdreq` is ignored because the FIFO is empty that cycle. The byte is stored.
- Reset mid-frame: FSM goes to IDLE, counters and pointers clear, in-flight byte is lost, FIFO contents are discarded.

## Timing
- Reset values:
  - `empty`=1
  - `full`=0
  - `q`=8'h00
  - `frame_err`=0
  - `overrun`=0
  - FSM in IDLE
  - synchronizer flops at 1
- Input latency: an edge on `rx` is visible to the FSM 2 cycles later.
- Start to push: push is asserted in the cycle the stop bit is sampled. This is the edge ending cycle (`CLKS_PER_BIT`/2) + 9·`CLKS_PER_BIT` after the FSM leaves IDLE.
- After push: `empty` falls and `q` is valid on the cycle after the push edge.
- Pop: `rdreq` high at edge N means `q` shows the next entry (or 0/`empty`) after edge N. Back-to-back pops every cycle are supported.
- `frame_err` and `overrun` are high for exactly one cycle, coincident with the push edge. They are registered, so they are visible the cycle after.

## Test plan
1. Single byte: with `CLKS_PER_BIT`=8, send 0xA5 8N1 → `empty` falls once. `q`=0xA5. One `rdreq` pulse → `empty`=1, `q`=0x00.
2. Glitch rejection: drive `rx` low for 2 cycles then high → no push, FSM returns to IDLE, `empty` stays 1. Then send 0x3C → `q`=0x3C.
3. Framing error: send 0x55 with the stop bit low, hold `rx` low for 40 cycles, then release high → exactly one `frame_err` pulse and no push. The next frame 0x01 is received correctly.
4. Overrun: with `DEPTH`=4, send 0x10..0x14 without reading → `full`=1 after 0x13, one `overrun` pulse on 0x14. Reading 4 times yields 0x10, 0x11, 0x12, 0x13, then `empty`.
5. Simultaneous push and pop when full: `DEPTH`=4 full with 0x20..0x23. Assert `rdreq` on the push cycle of 0x24 → no `overrun`, `full` stays 1. Drain order is 0x21, 0x22, 0x23, 0x24.
6. Reset mid-frame: assert `rst` for 1 cycle during DATA bit 4 of 0xFF, with 2 bytes already queued → `empty`=1, `q`=0. No byte appears from the aborted frame, and a subsequent full frame 0x7E is received correctly.
